uart_tx_mmio: RTL and testbench

- Memory-mapped console transmitter: the responder side of the core's MEM-stage data-store interface.
- Sits beside the data RAM on the same MEM-stage address, write-enable and store-data lines.
- Claims byte stores to TX_ADDR, queues them in a small FIFO and serialises each byte as 8N1 UART frames on txd.
- Exposes a status word at STAT_ADDR so firmware can poll before writing.

---
 rtl/riscv_periph_pkg.sv | 28 ++
 rtl/uart_tx_fifo.sv | 53 +++++
 rtl/uart_tx_mmio.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_periph_pkg.sv
// Shared constants for MEM-stage peripherals: default addresses, UART TX FSM states, status bit layout.
// Declarations only; no timing or flow control of its own.
package riscv_periph_pkg;

    localparam logic [7:0] TX_ADDR_DEF   = 8'hFF;
    localparam logic [7:0] STAT_ADDR_DEF = 8'hFE;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_BUSY_BIT  = 2;
    localparam int ST_OVF_BIT   = 3;
    localparam int ST_CNT_LSB   = 4;
    localparam int ST_CNT_MSB   = 7;

    // The status field is 4 bits wide, so deeper FIFOs report 15.
    function automatic logic [3:0] sat_count(input logic [31:0] c);
        return (c > 32'd15) ? 4'hF : c[3:0];
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with a combinational head. A pop is ignored when empty.
// A push is refused when full, unless a pop happens in the same cycle.
module uart_tx_fifo #(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + AW'(1);
            if (do_pop)  rptr_q <= rptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; the pointers define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter (even parity bit when UART_TX_PARITY_EN is defined); status read data is valid one cycle after the load.
// A push to TX_ADDR arriving when the FIFO is full (with no pop that cycle) is dropped and sets a sticky overflow flag; the first txd start bit follows a push by two edges.
module uart_tx_mmio
    import riscv_periph_pkg::*;
#(
    parameter int         CLKS_PER_BIT = 16,
    parameter int         FIFO_DEPTH   = 8,
    parameter logic [7:0] TX_ADDR      = TX_ADDR_DEF,
    parameter logic [7:0] STAT_ADDR    = STAT_ADDR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wren,
    input  logic        rden,
    input  logic [7:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        hit,
    output logic        txd
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam int            AW        = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   dout_q, dout_d;
    logic [31:0]   status;

    logic          push_req;
    logic          stat_rd;
    logic          pop;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic [7:0]    rdata;
    logic          baud_done;
    logic          unused_din_hi;

`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign push_req      = wren && (addr == TX_ADDR);
    assign stat_rd       = rden && (addr == STAT_ADDR);
    assign hit           = (wren || rden) && ((addr == TX_ADDR) || (addr == STAT_ADDR));
    assign baud_done     = (baud_q == BAUD_LAST);
    assign unused_din_hi = ^din[31:8];
    assign txd           = txd_q;
    assign dout          = dout_q;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .wdata (din[7:0]),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // txd is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = rdata;
                    bit_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            PARITY: begin
`ifdef UART_TX_PARITY_EN
                txd_d = parity_q;
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = STOP;
                end
`else
                baud_d  = '0;
                state_d = STOP;
`endif
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                baud_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef UART_TX_PARITY_EN
    assign parity_d = pop ? ^rdata : parity_q;
`endif

    always_comb begin
        status                         = '0;
        status[ST_FULL_BIT]            = full;
        status[ST_EMPTY_BIT]           = empty;
        status[ST_BUSY_BIT]            = (state_q != IDLE);
        status[ST_OVF_BIT]             = ovf_q;
        status[ST_CNT_MSB:ST_CNT_LSB]  = sat_count(32'(count));
    end

    // A drop in the same cycle as the status read wins over read-to-clear.
    always_comb begin
        ovf_d  = ovf_q;
        dout_d = dout_q;
        if (stat_rd) begin
            ovf_d  = 1'b0;
            dout_d = status;
        end
        if (push_req && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
            dout_q   <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
            ovf_q    <= ovf_d;
            dout_q   <= dout_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4; frame patterns are written out
// per bit period (nibble F = line high for one bit, 0 = low), earliest bit in the MSB.
module tb_uart_tx_mmio;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic        rden;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        hit;
    logic        txd;

    int          total = 0;
    int          bad   = 0;
    logic [127:0] sh;
    logic        quiet;

    uart_tx_mmio #(
        .CLKS_PER_BIT (4),
        .FIFO_DEPTH   (4),
        .TX_ADDR      (8'hFF),
        .STAT_ADDR    (8'hFE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .wren  (wren),
        .rden  (rden),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .hit   (hit),
        .txd   (txd)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        wren = 1'b1;
        addr = a;
        din  = {24'hABCDEF, d};
        tick();
        wren = 1'b0;
        addr = 8'h00;
    endtask

    task automatic stat_read();
        rden = 1'b1;
        addr = 8'hFE;
        tick();
        rden = 1'b0;
        addr = 8'h00;
    endtask

    // Sample txd, then advance one cycle; the first sample is the current cycle.
    task capture(input int n);
        for (int i = 0; i < n; i++) begin
            sh = {sh[126:0], txd};
            tick();
        end
    endtask

    initial begin
        sh    = '0;
        reset = 1'b1;
        wren  = 1'b0;
        rden  = 1'b0;
        addr  = 8'h00;
        din   = 32'h0;
        repeat (3) tick();
        check("reset_txd", 64'(txd), 64'h1);
        check("reset_dout", 64'(dout), 64'h0);
        check("reset_hit", 64'(hit), 64'h0);
        reset = 1'b0;
        tick();
        stat_read();
        check("reset_status", 64'(dout), 64'h2);

`ifndef UART_TX_PARITY_EN
        // Single byte 0x41 with a status read held during the frame.
        store(8'hFF, 8'h41);
        tick();
        check("t1_idle_before_start", 64'(txd), 64'h1);
        tick();
        rden = 1'b1;
        addr = 8'hFE;
        capture(20);
        check("t1_busy_status", 64'(dout), 64'h6);
        rden = 1'b0;
        addr = 8'h00;
        capture(20);
        check("t1_frame_41", 64'(sh[39:0]), 64'h0F00000F0F);
        repeat (3) tick();
        stat_read();
        check("t1_status_after", 64'(dout), 64'h2);

        // Three back-to-back bytes separated by exactly one idle cycle.
        store(8'hFF, 8'h55);
        store(8'hFF, 8'hAA);
        store(8'hFF, 8'h0F);
        capture(122);
        check("t2_frame_55", 64'(sh[121:82]), 64'h0F0F0F0F0F);
        check("t2_gap1", 64'(sh[81]), 64'h1);
        check("t2_frame_AA", 64'(sh[80:41]), 64'h00F0F0F0FF);
        check("t2_gap2", 64'(sh[40]), 64'h1);
        check("t2_frame_0F", 64'(sh[39:0]), 64'h0FFFF0000F);
        stat_read();
        check("t2_status_final", 64'(dout), 64'h2);
`endif

        // Fill the FIFO while the first byte is on the line, then overflow it.
        store(8'hFF, 8'h11);
        store(8'hFF, 8'h22);
        store(8'hFF, 8'h33);
        store(8'hFF, 8'h44);
        store(8'hFF, 8'h55);
        stat_read();
        check("t3_full_status", 64'(dout), 64'h45);
        store(8'hFF, 8'h66);
        stat_read();
        check("t3_overflow_set", 64'(dout), 64'h4D);
        stat_read();
        check("t3_overflow_cleared", 64'(dout), 64'h45);
        repeat (260) tick();
        stat_read();
        check("t3_drained", 64'(dout), 64'h2);

        // Address decode: STAT_ADDR store is claimed but ignored, other addresses are not claimed.
        wren = 1'b1;
        addr = 8'hFE;
        din  = 32'h0000_0077;
        #1;
        check("t4_hit_store_fe", 64'(hit), 64'h1);
        tick();
        addr = 8'h10;
        #1;
        check("t4_hit_store_10", 64'(hit), 64'h0);
        tick();
        wren = 1'b0;
        rden = 1'b1;
        #1;
        check("t4_hit_read_10", 64'(hit), 64'h0);
        tick();
        addr = 8'hFF;
        #1;
        check("t4_hit_read_ff", 64'(hit), 64'h1);
        tick();
        rden = 1'b0;
        addr = 8'h00;
        check("t4_dout_unchanged", 64'(dout), 64'h2);
        quiet = 1'b1;
        repeat (12) begin
            quiet &= txd;
            tick();
        end
        check("t4_no_frame", 64'(quiet), 64'h1);
        stat_read();
        check("t4_status", 64'(dout), 64'h2);

        // Reset during the third data bit of 0x33 with two bytes still queued.
        store(8'hFF, 8'h33);
        store(8'hFF, 8'h44);
        store(8'hFF, 8'h66);
        repeat (12) tick();
        check("t5_data_bit2", 64'(txd), 64'h0);
        reset = 1'b1;
        tick();
        check("t5_txd_after_reset", 64'(txd), 64'h1);
        tick();
        reset = 1'b0;
        stat_read();
        check("t5_status", 64'(dout), 64'h2);
        quiet = 1'b1;
        repeat (60) begin
            quiet &= txd;
            tick();
        end
        check("t5_no_frame", 64'(quiet), 64'h1);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three set bits, so even parity drives a 1.
        store(8'hFF, 8'h07);
        tick();
        tick();
        capture(44);
        check("t6_frame_parity_07", 64'(sh[43:0]), 64'h0FFF00000FF);
        tick();
        stat_read();
        check("t6_status", 64'(dout), 64'h2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
